// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter
// Iterative AES inverse cipher. One decryption round per clock on a single
// 128-bit state register; the round count (10/12/14) is chosen per block.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   i_valid/i_ready/i_data   ciphertext input handshake
//   NR             rounds for the block (10, 12 or 14)
//   expanded_key   packed round keys, RK(r) = expanded_key[KEY_W-1-128*r -: 128]
//   o_valid/o_ready/o_data   plaintext output handshake
//   o_err          one-cycle pulse when a block with an illegal NR is rejected
//
// Parameters:
//   LATCH_KEY  1: capture expanded_key and NR on accept; 0: caller holds them
//   KEY_W      expanded key width (15 round keys x 128)
//
// Optional feature macro: INV_CIPHER_NR_CHECK_EN
//   defined   : blocks with NR not in {10,12,14} are consumed and dropped,
//               o_err pulses for one cycle
//   undefined : o_err tied 0, NR clamped (below 2 -> 10, above 14 -> 14)
module inv_cipher_iter #(
    parameter int LATCH_KEY = 1,
    parameter int KEY_W     = 1920
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [127:0]     i_data,
    input  logic [3:0]       NR,
    input  logic [KEY_W-1:0] expanded_key,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [127:0]     o_data,
    output logic             o_err
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t           state, next_state;
    logic [127:0]     st;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] key_use;
    logic [3:0]       nr_in, nr_use, key_idx;
    logic             accept, reject, load, last_round;
    logic [127:0]     sb, ark, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    // Inverse affine transform followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w)&3)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]  = s[127-32*c-8*i -: 8];
                x2    = xtime(a[i]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[i] = x8 ^ a[i];
                mb[i] = x8 ^ x2 ^ a[i];
                md[i] = x8 ^ x4 ^ a[i];
                me[i] = x8 ^ x4 ^ x2;
            end
            r[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
        return r;
    endfunction

    function automatic logic [127:0] round_key(input logic [KEY_W-1:0] key, input logic [3:0] idx);
        logic [KEY_W-1:0] sh;
        sh = key << (128 * idx);
        return sh[KEY_W-1 -: 128];
    endfunction

    // Out-of-range round counts still give a terminating schedule
    function automatic logic [3:0] clamp_nr(input logic [3:0] n);
        if (n < 4'd2)  return 4'd10;
        if (n > 4'd14) return 4'd14;
        return n;
    endfunction

    assign nr_in  = clamp_nr(NR);
    assign accept = i_valid & i_ready;
    assign load   = accept & ~reject;

`ifdef INV_CIPHER_NR_CHECK_EN
    assign reject = accept && !(NR == 4'd10 || NR == 4'd12 || NR == 4'd14);

    // Rejected blocks report one cycle after the consuming handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_err <= 1'b0;
        else     o_err <= reject;
    end
`else
    assign reject = 1'b0;
    assign o_err  = 1'b0;
`endif

    // Key and round count used during ROUND/FINAL
    if (LATCH_KEY != 0) begin : g_latch
        logic [KEY_W-1:0] key_q;
        logic [3:0]       nr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                key_q <= '0;
                nr_q  <= 4'd0;
            end else if (load) begin
                key_q <= expanded_key;
                nr_q  <= nr_in;
            end
        end

        assign key_use = key_q;
        assign nr_use  = nr_q;
    end else begin : g_live
        assign key_use = expanded_key;
        assign nr_use  = nr_in;
    end

    // Shared round datapath: FINAL reuses the same shift/sub/add path with RK(0)
    assign last_round = (cnt == nr_use - 4'd1);
    assign key_idx    = (state == FINAL) ? 4'd0 : nr_use - cnt;
    assign sb         = inv_sub_bytes(inv_shift_rows(st));
    assign ark        = sb ^ round_key(key_use, key_idx);
    assign round_out  = inv_mix_columns(ark);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; DONE can hand straight over to a new block
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = reject ? IDLE : ROUND;
            ROUND:   if (last_round) next_state = FINAL;
            FINAL:   next_state = DONE;
            DONE:    if (o_ready) next_state = load ? ROUND : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; in DONE input readiness follows downstream readiness
    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE: i_ready = 1'b1;
            DONE: begin
                i_ready = o_ready;
                o_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // State/counter/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= '0;
            cnt    <= 4'd0;
            o_data <= '0;
        end else begin
            if (load) begin
                st  <= i_data ^ round_key(expanded_key, nr_in);
                cnt <= 4'd1;
            end else if (state == ROUND) begin
                st  <= round_out;
                cnt <= cnt + 4'd1;
            end
            if (state == FINAL) o_data <= ark;
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter
// Directed bench for inv_cipher_iter using FIPS-197 vectors. Round keys are
// expanded here from the cipher keys; expected plaintexts are queued when a
// block is offered and popped when the DUT presents o_valid.
module tb_inv_cipher_iter;

    localparam int KEY_W = 1920;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid, i_ready, o_valid, o_ready, o_err;
    logic [127:0]     i_data, o_data;
    logic [3:0]       nr;
    logic [KEY_W-1:0] expanded_key;
    logic [KEY_W-1:0] ek128, ek192, ek256;

    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           err_cycles   = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sbox [256];

    always #5 clk = ~clk;

    inv_cipher_iter dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_data       (i_data),
        .NR           (nr),
        .expanded_key (expanded_key),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_err        (o_err)
    );

    // Count every cycle in which the error pulse is visible
    always @(negedge clk) if (o_err === 1'b1) err_cycles = err_cycles + 1;

    // Forward S-box from the log/antilog generator walk (3 and its inverse)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int k = 0; k < 255; k++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Standard key schedule; key is left-aligned in 256 bits
    function automatic logic [KEY_W-1:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]      w [60];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [KEY_W-1:0] ek;
        int               nrounds;
        nrounds = nk + 6;
        rc = 8'h01;
        ek = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nrounds+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nrounds+1); i++) ek[KEY_W-1-32*i -: 32] = w[i];
        return ek;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer one block at a negedge; it must be accepted on the next edge
    task automatic apply_stimulus(input string tag, input logic [127:0] data, input logic [3:0] nr_val,
                                  input logic [KEY_W-1:0] key, input logic [127:0] expected,
                                  input bit push, input bit scramble);
        i_data       = data;
        nr           = nr_val;
        expanded_key = key;
        i_valid      = 1'b1;
        #1;
        check_output({tag, "_ready"}, 128'(i_ready), 128'd1);
        if (push) exp_q.push_back(expected);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = '0;
        if (scramble) begin
            for (int k = 0; k < KEY_W/32; k++) expanded_key[32*k +: 32] = $urandom;
            nr = 4'($urandom_range(0, 15));
        end
    endtask

    // Count negedges after the accept edge until o_valid, then score o_data
    task automatic wait_output(input string tag, input int exp_latency);
        int           cycles;
        logic [127:0] exp;
        cycles = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            cycles++;
            if (o_valid === 1'b1) break;
        end
        check_output({tag, "_latency"}, 128'(cycles), 128'(exp_latency));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check_output({tag, "_data"}, o_data, exp);
    endtask

    initial begin
        int valid_seen;

        rst          = 1'b1;
        i_valid      = 1'b0;
        o_ready      = 1'b1;
        i_data       = '0;
        nr           = 4'd0;
        expanded_key = '0;
        build_sbox();
        ek128 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        ek192 = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        ek256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        $display("[TB] reset values");
        repeat (2) @(negedge clk);
        check_output("rst_i_ready", 128'(i_ready), 128'd1);
        check_output("rst_o_valid", 128'(o_valid), 128'd0);
        check_output("rst_o_data", o_data, 128'd0);
        check_output("rst_o_err", 128'(o_err), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single blocks for each key size");
        apply_stimulus("aes128", CT128, 4'd10, ek128, PT, 1'b1, 1'b0);
        wait_output("aes128", 11);
        @(negedge clk);
        check_output("aes128_release", 128'(o_valid), 128'd0);
        apply_stimulus("aes192", CT192, 4'd12, ek192, PT, 1'b1, 1'b0);
        wait_output("aes192", 13);
        @(negedge clk);
        apply_stimulus("aes256", CT256, 4'd14, ek256, PT, 1'b1, 1'b0);
        wait_output("aes256", 15);
        @(negedge clk);

        $display("[TB] output backpressure");
        o_ready = 1'b0;
        apply_stimulus("bp_first", CT128, 4'd10, ek128, PT, 1'b1, 1'b0);
        wait_output("bp_first", 11);
        i_data       = CT192;
        nr           = 4'd12;
        expanded_key = ek192;
        i_valid      = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("bp_hold_valid", 128'(o_valid), 128'd1);
            check_output("bp_hold_data", o_data, PT);
            check_output("bp_hold_i_ready", 128'(i_ready), 128'd0);
        end
        o_ready = 1'b1;
        apply_stimulus("bp_second", CT192, 4'd12, ek192, PT, 1'b1, 1'b0);
        wait_output("bp_second", 13);

        $display("[TB] mixed modes back to back with key scrambling");
        apply_stimulus("mix256", CT256, 4'd14, ek256, PT, 1'b1, 1'b1);
        wait_output("mix256", 15);
        apply_stimulus("mix128", CT128, 4'd10, ek128, PT, 1'b1, 1'b1);
        wait_output("mix128", 11);
        apply_stimulus("mix192", CT192, 4'd12, ek192, PT, 1'b1, 1'b1);
        wait_output("mix192", 13);
        @(negedge clk);

        $display("[TB] reset in the middle of a block");
        apply_stimulus("rst_mid", CT256, 4'd14, ek256, PT, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_output("rst_mid_busy", 128'(i_ready), 128'd0);
        rst = 1'b1;
        #1;
        check_output("rst_mid_o_valid", 128'(o_valid), 128'd0);
        check_output("rst_mid_i_ready", 128'(i_ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        valid_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) valid_seen++;
        end
        check_output("rst_mid_no_output", 128'(valid_seen), 128'd0);
        apply_stimulus("post_rst", CT256, 4'd14, ek256, PT, 1'b1, 1'b0);
        wait_output("post_rst", 15);
        @(negedge clk);

`ifdef INV_CIPHER_NR_CHECK_EN
        $display("[TB] illegal round count rejected");
        apply_stimulus("nrchk11", CT128, 4'd11, ek128, PT, 1'b0, 1'b0);
        check_output("nrchk_err_hi", 128'(o_err), 128'd1);
        @(negedge clk);
        check_output("nrchk_err_lo", 128'(o_err), 128'd0);
        check_output("nrchk_idle", 128'(i_ready), 128'd1);
        valid_seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) valid_seen++;
        end
        check_output("nrchk_no_output", 128'(valid_seen), 128'd0);
        check_output("nrchk_err_width", 128'(err_cycles), 128'd1);
        apply_stimulus("nrchk_after", CT128, 4'd10, ek128, PT, 1'b1, 1'b0);
        wait_output("nrchk_after", 11);
        @(negedge clk);
`else
        $display("[TB] out-of-range round counts are clamped");
        apply_stimulus("clamp15", CT256, 4'd15, ek256, PT, 1'b1, 1'b0);
        wait_output("clamp15", 15);
        @(negedge clk);
        apply_stimulus("clamp1", CT128, 4'd1, ek128, PT, 1'b1, 1'b0);
        wait_output("clamp1", 11);
        @(negedge clk);
        check_output("no_err_pulse", 128'(err_cycles), 128'd0);
`endif

        check_output("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
